// File: rtl/onewire_pkg.sv
// ============================================================================
// Module : onewire_pkg
// Brief  : Shared 1-Wire timing defaults, reader state encoding and command bytes
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package onewire_pkg;

    // Read-slot timing defaults, 1 clk tick = 1 us
    localparam int c_T_LOW_DEF    = 2;
    localparam int c_T_SAMPLE_DEF = 13;
    localparam int c_T_SLOT_DEF   = 60;
    localparam int c_T_REC_DEF    = 11;

    // Byte reader state encoding
    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_SLOT     = 2'd1;
    localparam logic [1:0] c_ST_RECOVERY = 2'd2;
    localparam logic [1:0] c_ST_DONE     = 2'd3;

    // Skip-command sender constants
    localparam logic [7:0] c_CMD_SKIP_ROM  = 8'hCC;
    localparam int         c_T_WRITE0_LOW  = 60;
    localparam int         c_T_WRITE1_LOW  = 6;

    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/onewire_bus_sync.sv
// ============================================================================
// Module : onewire_bus_sync
// Brief  : Two-flop synchronizer for the open-drain bus; idles high (released)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module onewire_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

`default_nettype wire

// File: rtl/onewire_byte_reader.sv
// ============================================================================
// Module : onewire_byte_reader
// Brief  : Reads one byte (LSB first) as eight 1-Wire read slots
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module onewire_byte_reader
    import onewire_pkg::*;
#(
    parameter int T_LOW    = c_T_LOW_DEF,
    parameter int T_SAMPLE = c_T_SAMPLE_DEF,
    parameter int T_SLOT   = c_T_SLOT_DEF,
    parameter int T_REC    = c_T_REC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_byte_reader,
    input  logic       bus,
    output logic       master_pull_low,
    output logic       done_byte_reading,
    output logic [7:0] data_out
);

    localparam int c_CNT_W = $clog2(f_max(f_max(T_SLOT, T_REC), 2));

    localparam logic [c_CNT_W-1:0] c_LOW_CMP   = c_CNT_W'(T_LOW);
    localparam logic [c_CNT_W-1:0] c_SAMPLE_AT = c_CNT_W'(T_SAMPLE);
    localparam logic [c_CNT_W-1:0] c_SLOT_LAST = c_CNT_W'(T_SLOT - 1);
    localparam logic [c_CNT_W-1:0] c_REC_LAST  = c_CNT_W'(T_REC - 1);

    generate
        if (!((T_LOW < T_SAMPLE) && (T_SAMPLE < T_SLOT))) begin : g_bad_timing
            $error("onewire_byte_reader: requires T_LOW < T_SAMPLE < T_SLOT");
        end
    endgenerate

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_CNT_W-1:0] r_slot_cnt;
    logic [c_CNT_W-1:0] w_next_cnt;
    logic [2:0]         r_bit_idx;
    logic [2:0]         w_next_bit;
    logic [7:0]         r_shift;
    logic [7:0]         r_data;
    logic               r_pull;
    logic               r_done;
    logic               w_bus_sync;
    logic               w_pull_next;
    logic               w_done_next;
    logic               w_sample;
    logic               w_load;

    onewire_bus_sync u_bus_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus),
        .o_sync  (w_bus_sync)
    );

    // State, counters and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_slot_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_data     <= 8'h00;
            r_pull     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_slot_cnt <= w_next_cnt;
            r_bit_idx  <= w_next_bit;
            r_pull     <= w_pull_next;
            r_done     <= w_done_next;
            if (w_sample) begin
                r_shift[r_bit_idx] <= w_bus_sync;
            end
            if (w_load) begin
                r_data <= r_shift;
            end
        end
    end

    // Next-state logic; dropping the enable mid-byte returns straight to IDLE
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_slot_cnt;
        w_next_bit   = r_bit_idx;
        case (r_state)
            c_ST_IDLE: begin
                if (en_byte_reader) begin
                    w_next_state = c_ST_SLOT;
                    w_next_cnt   = '0;
                    w_next_bit   = '0;
                end
            end
            c_ST_SLOT: begin
                if (!en_byte_reader) begin
                    w_next_state = c_ST_IDLE;
                    w_next_cnt   = '0;
                    w_next_bit   = '0;
                end else if (r_slot_cnt == c_SLOT_LAST) begin
                    w_next_state = c_ST_RECOVERY;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt   = r_slot_cnt + 1'b1;
                end
            end
            c_ST_RECOVERY: begin
                if (!en_byte_reader) begin
                    w_next_state = c_ST_IDLE;
                    w_next_cnt   = '0;
                    w_next_bit   = '0;
                end else if (r_slot_cnt == c_REC_LAST) begin
                    w_next_cnt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_next_state = c_ST_DONE;
                    end else begin
                        w_next_state = c_ST_SLOT;
                        w_next_bit   = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_next_cnt = r_slot_cnt + 1'b1;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
                w_next_cnt   = '0;
                w_next_bit   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with the state
    always_comb begin
        w_pull_next = (w_next_state == c_ST_SLOT) && (w_next_cnt < c_LOW_CMP);
        w_done_next = (w_next_state == c_ST_DONE);
        w_sample    = (r_state == c_ST_SLOT) && (r_slot_cnt == c_SAMPLE_AT);
        w_load      = (r_state == c_ST_RECOVERY) && (w_next_state == c_ST_DONE);
    end

    assign master_pull_low   = r_pull;
    assign done_byte_reading = r_done;
    assign data_out          = r_data;

endmodule

`default_nettype wire
